// File: rtl/pc_fetch_if.sv
// Bundle of every non-clock/reset signal of the PC/fetch unit: the adder
// operand/result pair, the datapath redirect requests, the instruction
// memory port and the decode handshake.
// master = the fetch unit, slave = its surroundings (adder, datapath,
// instruction memory, decode).
//
// Handshakes:
//   imem: imem_req is held high with imem_addr stable until a cycle in which
//         imem_ack is high; imem_rdata is sampled in that same cycle.
//   decode: instr/instr_pc are stable while instr_valid is high; a transfer
//         happens on every rising edge where instr_valid && instr_ready.
interface pc_fetch_if;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic [31:0] add_out;
  logic        add_carry;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        pc_fault;

  modport master (
    output add_in1, add_in2,
    input  add_out, add_carry,
    input  branch_valid, branch_target, jump_valid, jump_target,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output pc_fault
  );

  modport slave (
    input  add_in1, add_in2,
    output add_out, add_carry,
    output branch_valid, branch_target, jump_valid, jump_target,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  pc_fault
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction-fetch sequencer.
// The sequential next PC comes from the external 32-bit adder (add_in1=PC,
// add_in2=PC_STEP); a carry-out on that increment raises a sticky pc_fault.
// Branch/jump redirects are captured in a single pending slot (jump wins,
// newest wins) and applied at the next point the PC would move.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined     : a misaligned redirect target faults and halts the unit
//   not defined : target[1:0] is cleared on load
// dbg_state exposes the FSM state encoding (0 IDLE, 1 REQ, 2 HOLD, 3 HALT).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] ipc_q, ipc_n;
  logic        fault_q, fault_n;
  logic        pend_q, pend_n;
  logic [31:0] pend_tgt_q, pend_tgt_n;

  logic        redir_now;
  logic [31:0] redir_tgt;
  logic        eff_pend;
  logic [31:0] eff_tgt;
  logic [31:0] load_tgt;
  logic        misaligned;

  // Merge a redirect arriving this cycle with the pending one; jump has
  // priority over branch and the newest request replaces an older one.
  always_comb begin
    redir_now = bus.jump_valid | bus.branch_valid;
    redir_tgt = bus.jump_valid ? bus.jump_target : bus.branch_target;
    eff_pend  = pend_q | redir_now;
    eff_tgt   = redir_now ? redir_tgt : pend_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
    load_tgt   = eff_tgt;
    misaligned = |eff_tgt[1:0];
`else
    load_tgt   = eff_tgt & 32'hFFFF_FFFC;
    misaligned = 1'b0;
`endif
  end

  // Next-state and next-register values for the fetch sequencer.
  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    instr_n    = instr_q;
    ipc_n      = ipc_q;
    fault_n    = fault_q;
    pend_n     = eff_pend;
    pend_tgt_n = eff_tgt;
    case (state_q)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (bus.imem_ack) begin
          if (eff_pend) begin
            // The returning word belongs to the stale path: drop it.
            pend_n = 1'b0;
            if (misaligned) begin
              fault_n = 1'b1;
              state_n = S_HALT;
            end else begin
              pc_n    = load_tgt;
              state_n = S_REQ;
            end
          end else begin
            instr_n = bus.imem_rdata;
            ipc_n   = pc_q;
            pc_n    = bus.add_out;
            fault_n = fault_q | bus.add_carry;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          state_n = S_REQ;
          if (eff_pend) begin
            pend_n = 1'b0;
            if (misaligned) begin
              fault_n = 1'b1;
              state_n = S_HALT;
            end else begin
              pc_n = load_tgt;
            end
          end
        end
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      ipc_q      <= 32'h0;
      fault_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      instr_q    <= instr_n;
      ipc_q      <= ipc_n;
      fault_q    <= fault_n;
      pend_q     <= pend_n;
      pend_tgt_q <= pend_tgt_n;
    end
  end

  // Output decode: adder operands are live at all times.
  always_comb begin
    bus.add_in1     = pc_q;
    bus.add_in2     = PC_STEP;
    bus.imem_req    = (state_q == S_REQ);
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == S_HOLD);
    bus.instr       = instr_q;
    bus.instr_pc    = ipc_q;
    bus.pc_fault    = fault_q;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a main instance (RESET_PC=0) checked through
// address/instruction scoreboards, plus a second instance (RESET_PC at the
// top of the address space) exercising PC wrap and the sticky fault.
module tb_pc_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_if bus ();
  pc_fetch_if bus_w ();
  logic [1:0] dbg_state, dbg_state_w;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state));

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w), .dbg_state(dbg_state_w));

  // External 33-bit adder model for both instances.
  logic [32:0] sum, sum_w;
  assign sum = {1'b0, bus.add_in1} + {1'b0, bus.add_in2};
  assign bus.add_out = sum[31:0];
  assign bus.add_carry = sum[32];
  assign sum_w = {1'b0, bus_w.add_in1} + {1'b0, bus_w.add_in2};
  assign bus_w.add_out = sum_w[31:0];
  assign bus_w.add_carry = sum_w[32];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory models ----------------
  int   credits = 0;
  logic req_wait = 1'b0;
  logic force_ack = 1'b0;
  logic w_en = 1'b0;

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.branch_valid = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump_valid = 1'b0;
    bus.jump_target = 32'h0;
    bus.instr_ready = 1'b0;
    bus_w.imem_ack = 1'b0;
    bus_w.imem_rdata = 32'h0;
    bus_w.branch_valid = 1'b0;
    bus_w.branch_target = 32'h0;
    bus_w.jump_valid = 1'b0;
    bus_w.jump_target = 32'h0;
    bus_w.instr_ready = 1'b1;
  end

  // Main memory: acks one cycle after it first sees a request, while credits last.
  always @(negedge clk) begin
    if (bus.imem_ack) begin
      bus.imem_ack = 1'b0;
      req_wait = 1'b0;
    end else if (force_ack) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end else if (credits > 0 && bus.imem_req) begin
      if (req_wait) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        credits--;
      end else begin
        req_wait = 1'b1;
      end
    end else begin
      req_wait = 1'b0;
    end
  end

  // Wrap-instance memory: immediate ack while enabled.
  always @(negedge clk) begin
    if (bus_w.imem_ack) bus_w.imem_ack = 1'b0;
    else if (w_en && bus_w.imem_req) begin
      bus_w.imem_ack = 1'b1;
      bus_w.imem_rdata = mem_word(bus_w.imem_addr);
    end
  end

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #2;
    if (rst_n && bus.imem_req && bus.imem_ack) begin
      if (exp_addr_q.size() == 0) chk("imem_addr_unexpected", {32'h0, bus.imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("imem_addr", {32'h0, bus.imem_addr}, {32'h0, exp_addr_q.pop_front()});
    end
    if (rst_n && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) chk("instr_unexpected", {bus.instr_pc, bus.instr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("instr_pc_and_word", {bus.instr_pc, bus.instr}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_instr(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drain_left"}, 64'(exp_addr_q.size() + exp_q.size()), 64'd0);
    exp_addr_q.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_valid_main(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!bus.instr_valid && n < 50);
    chk({name, "_valid_timeout"}, {63'h0, bus.instr_valid}, 64'd1);
  endtask

  task automatic wait_w(input string name, input bit want_valid);
    int n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while ((want_valid ? !bus_w.instr_valid : !bus_w.imem_req) && n < 50);
    chk({name, "_timeout"}, 64'(want_valid ? bus_w.instr_valid : bus_w.imem_req), 64'd1);
  endtask

  task automatic redirect(input bit j, input logic [31:0] jt, input bit b, input logic [31:0] bt);
    bus.jump_valid = j;
    bus.jump_target = jt;
    bus.branch_valid = b;
    bus.branch_target = bt;
    @(negedge clk);
    bus.jump_valid = 1'b0;
    bus.branch_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_imem_req", {63'h0, bus.imem_req}, 64'd0);
    chk("rst_instr_valid", {63'h0, bus.instr_valid}, 64'd0);
    chk("rst_instr", {32'h0, bus.instr}, 64'd0);
    chk("rst_instr_pc", {32'h0, bus.instr_pc}, 64'd0);
    chk("rst_pc_fault", {63'h0, bus.pc_fault}, 64'd0);
    chk("rst_add_in1", {32'h0, bus.add_in1}, 64'd0);
    chk("rst_add_in2", {32'h0, bus.add_in2}, 64'd4);

    // 1: sequential fetch with ready decode
    bus.instr_ready = 1'b1;
    credits = 3;
    push_fetch(32'h0); push_instr(32'h0);
    push_fetch(32'h4); push_instr(32'h4);
    push_fetch(32'h8); push_instr(32'h8);
    rst_n = 1'b1;
    drain("t1");

    // 2: decode backpressure (unit now waits on fetch of 0xC)
    bus.instr_ready = 1'b0;
    push_fetch(32'hC);
    credits = 2;
    wait_valid_main("t2");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_instr", {32'h0, bus.instr}, {32'h0, mem_word(32'hC)});
      chk("t2_hold_instr_pc", {32'h0, bus.instr_pc}, 64'hC);
      chk("t2_hold_no_req", {63'h0, bus.imem_req}, 64'd0);
      @(negedge clk);
      #3;
    end
    push_instr(32'hC);
    push_fetch(32'h10); push_instr(32'h10);
    @(negedge clk);
    bus.instr_ready = 1'b1;
    drain("t2");

    // 3: jump and branch together while fetch of 0x14 is outstanding
    redirect(1'b1, 32'h100, 1'b1, 32'h200);
    push_fetch(32'h14);
    push_fetch(32'h100); push_instr(32'h100);
    credits = 2;
    drain("t3");
    chk("t3_pc_after", {32'h0, bus.add_in1}, 64'h104);

    // 4: wrap from 0xFFFF_FFFC on the second instance
    chk("t4_start_addr", {32'h0, bus_w.imem_addr}, 64'hFFFF_FFFC);
    chk("t4_start_req", {63'h0, bus_w.imem_req}, 64'd1);
    chk("t4_start_fault", {63'h0, bus_w.pc_fault}, 64'd0);
    w_en = 1'b1;
    wait_w("t4_first", 1'b1);
    w_en = 1'b0;
    chk("t4_instr_pc", {32'h0, bus_w.instr_pc}, 64'hFFFF_FFFC);
    chk("t4_instr", {32'h0, bus_w.instr}, {32'h0, mem_word(32'hFFFF_FFFC)});
    chk("t4_pc_wrapped", {32'h0, bus_w.add_in1}, 64'h0);
    chk("t4_fault_set", {63'h0, bus_w.pc_fault}, 64'd1);
    wait_w("t4_req", 1'b0);
    chk("t4_next_addr", {32'h0, bus_w.imem_addr}, 64'h0);
    w_en = 1'b1;
    wait_w("t4_second", 1'b1);
    w_en = 1'b0;
    chk("t4_instr_pc2", {32'h0, bus_w.instr_pc}, 64'h0);
    chk("t4_fault_sticky", {63'h0, bus_w.pc_fault}, 64'd1);

    // 6: misaligned branch target 0x102 while fetch of 0x104 is outstanding
    redirect(1'b0, 32'h0, 1'b1, 32'h102);
    push_fetch(32'h104);
`ifdef PC_ALIGN_CHECK_EN
    credits = 2;
    drain("t6");
    repeat (3) @(negedge clk);
    #3;
    chk("t6_halt_req", {63'h0, bus.imem_req}, 64'd0);
    chk("t6_halt_valid", {63'h0, bus.instr_valid}, 64'd0);
    chk("t6_halt_fault", {63'h0, bus.pc_fault}, 64'd1);
`else
    push_fetch(32'h100); push_instr(32'h100);
    credits = 2;
    drain("t6");
    chk("t6_no_fault", {63'h0, bus.pc_fault}, 64'd0);
`endif
    credits = 0;

    // 5: reset pulse with an ack arriving during reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req", {63'h0, bus.imem_req}, 64'd0);
    chk("t5_rst_valid", {63'h0, bus.instr_valid}, 64'd0);
    chk("t5_rst_instr", {32'h0, bus.instr}, 64'd0);
    chk("t5_rst_instr_pc", {32'h0, bus.instr_pc}, 64'd0);
    chk("t5_rst_fault", {63'h0, bus.pc_fault}, 64'd0);
    chk("t5_rst_pc", {32'h0, bus.add_in1}, 64'd0);
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_ack = 1'b0;
    #1;
    chk("t5_ack_ignored_instr", {32'h0, bus.instr}, 64'd0);
    chk("t5_ack_ignored_pc", {32'h0, bus.add_in1}, 64'd0);
    @(negedge clk);
    push_fetch(32'h0); push_instr(32'h0);
    credits = 1;
    rst_n = 1'b1;
    drain("t5");
    chk("t5_fault_clear", {63'h0, bus.pc_fault}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
